// File: rtl/l2_port_arbiter_pkg.sv
// Shared types for the L2 port arbiter.
//   state_t  : arbiter FSM states
//   req_id_t : requester index (REQ_I = I-side L1, REQ_D = D-side L1)
//   op_t     : L2 command kind
package l2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ_I = 1'b0;
    localparam req_id_t REQ_D = 1'b1;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage

// File: rtl/l2_port_arbiter_if.sv
// Block-transfer port between a cache client and a cache server.
//   master : issues addr/wdata/read/write, receives rdata/ready/hit
//   slave  : receives the command, returns rdata/ready/hit
// The arbiter is a slave towards each L1 and a master towards the L2.
interface l2_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BLOCK_SIZE = 16
);

    logic [ADDR_WIDTH-1:0]                 addr;
    logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] wdata;
    logic                                  read;
    logic                                  write;
    logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] rdata;
    logic                                  ready;
    logic                                  hit;

    modport master (
        output addr, wdata, read, write,
        input  rdata, ready, hit
    );

    modport slave (
        input  addr, wdata, read, write,
        output rdata, ready, hit
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin winner select, purely combinational.
//   req        : request bits, index = requester id
//   last_grant : requester granted most recently
//   valid      : at least one request present
//   winner     : chosen requester (only meaningful when valid)
module rr_arbiter2
    import l2_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last_grant,
    output logic       valid,
    output req_id_t    winner
);

    always_comb begin
        valid  = |req;
        winner = REQ_I;
        if (req[0] && req[1]) begin
            winner = ~last_grant;
        end else if (req[1]) begin
            winner = REQ_D;
        end
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// Shares one L2 port between the I-side and D-side L1 caches, holding a
// grant until the L2 handshake completes.
//   clk, rst  : clock, asynchronous active-high reset
//   rq0, rq1  : L1 ports (slave), rq0 = I-side, rq1 = D-side
//   l2        : L2 port (master)
//   grant_id  : requester owning the L2 port
//   busy      : high whenever not IDLE
//
// state | meaning
// IDLE  | waiting for a request; winner latched on leaving
// ISSUE | L2 command held, waiting for l2.ready
// DONE  | ready pulse to the winner; requests not sampled
module l2_port_arbiter
    import l2_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BLOCK_SIZE = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    l2_port_arbiter_if.slave        rq0,
    l2_port_arbiter_if.slave        rq1,
    l2_port_arbiter_if.master       l2,
    output req_id_t                 grant_id,
    output logic                    busy
);

    typedef logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] block_t;

    state_t                state_q;
    state_t                state_d;
    req_id_t               last_grant_q;
    req_id_t               winner;
    logic                  win_valid;
    logic [1:0]            req_lvl;
    logic [ADDR_WIDTH-1:0] win_addr;
    block_t                win_wdata;
    op_t                   win_op;

    logic [ADDR_WIDTH-1:0] l2_addr_q;
    block_t                l2_wdata_q;
    logic                  l2_read_q;
    logic                  l2_write_q;
    block_t                rdata_q [2];
    logic [1:0]            hit_q;

    assign req_lvl = {rq1.read | rq1.write, rq0.read | rq0.write};

    rr_arbiter2 u_rr (
        .req        (req_lvl),
        .last_grant (last_grant_q),
        .valid      (win_valid),
        .winner     (winner)
    );

    // Write takes precedence when a requester raises both levels.
    always_comb begin
        win_addr  = rq0.addr;
        win_wdata = rq0.wdata;
        win_op    = rq0.write ? OP_WRITE : OP_READ;
        if (winner == REQ_D) begin
            win_addr  = rq1.addr;
            win_wdata = rq1.wdata;
            win_op    = rq1.write ? OP_WRITE : OP_READ;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_valid) state_d = ISSUE;
            ISSUE:   if (l2.ready)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_id     <= REQ_I;
            last_grant_q <= REQ_D;
            l2_addr_q    <= '0;
            l2_wdata_q   <= '0;
            l2_read_q    <= 1'b0;
            l2_write_q   <= 1'b0;
            rdata_q[0]   <= '0;
            rdata_q[1]   <= '0;
            hit_q        <= '0;
        end else begin
            if (state_q == IDLE && win_valid) begin
                grant_id     <= winner;
                last_grant_q <= winner;
                l2_addr_q    <= win_addr;
                l2_wdata_q   <= win_wdata;
                l2_read_q    <= (win_op == OP_READ);
                l2_write_q   <= (win_op == OP_WRITE);
            end
            if (state_q == ISSUE && l2.ready) begin
                rdata_q[grant_id] <= l2.rdata;
                hit_q[grant_id]   <= l2.hit;
                l2_read_q         <= 1'b0;
                l2_write_q        <= 1'b0;
            end
        end
    end

    assign l2.addr   = l2_addr_q;
    assign l2.wdata  = l2_wdata_q;
    assign l2.read   = l2_read_q;
    assign l2.write  = l2_write_q;

    // Ready is decoded from registered state only, so it never sees an input.
    assign rq0.ready = (state_q == DONE) && (grant_id == REQ_I);
    assign rq1.ready = (state_q == DONE) && (grant_id == REQ_D);
    assign rq0.rdata = rdata_q[0];
    assign rq1.rdata = rdata_q[1];
    assign rq0.hit   = hit_q[0];
    assign rq1.hit   = hit_q[1];

    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_l2_port_arbiter.sv
module tb_l2_port_arbiter;
    import l2_arb_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BS = 16;
    localparam int BW = DW * BS;

    logic    clk = 1'b0;
    logic    rst = 1'b1;
    req_id_t grant_id;
    logic    busy;

    always #5 clk = ~clk;

    l2_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS)) rq0_if ();
    l2_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS)) rq1_if ();
    l2_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS)) l2_if ();

    l2_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS)) dut (
        .clk      (clk),
        .rst      (rst),
        .rq0      (rq0_if),
        .rq1      (rq1_if),
        .l2       (l2_if),
        .grant_id (grant_id),
        .busy     (busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: transactions are placed on an edge timeline.
    // A grant at edge g with L2 latency k completes at edge g+k, the ready
    // pulse is visible after that edge, and the next grant may be at g+k+2.
    int n       = 0;
    int g       = -1000;
    int done_e  = -1000;
    int next_ok = 0;
    int cur_w   = 0;
    int last_w  = 1;
    int exp_gid = 0;

    bit              pend [2];
    bit              wr_r [2];
    logic [AW-1:0]   addr_r [2];
    logic [BW-1:0]   wdata_r [2];
    logic [AW-1:0]   exp_addr;
    logic [BW-1:0]   exp_wdata;
    bit              exp_wr;
    logic [BW-1:0]   exp_rdata [2];
    bit              exp_hit [2];

    bit              hold_mode = 1'b0;
    bit              auto_req  = 1'b0;
    bit              noise_one = 1'b0;
    int              k_force   = 0;
    bit              rd_force  = 1'b0;
    logic [BW-1:0]   rd_force_val;
    bit              hit_force_val;

    int obs_grant_edge [$];
    int obs_grant_id   [$];
    int obs_ready_edge [$];
    int rdy_cnt [2];
    bit cmd_prev = 1'b0;

    task automatic check_val(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n);
    endtask

    function automatic logic [BW-1:0] rand_blk();
        logic [BW-1:0] b;
        for (int i = 0; i < BS; i++) b[i*DW +: DW] = $urandom;
        return b;
    endfunction

    task automatic drive_req(input int r);
        logic rd, wr;
        wr = pend[r] && wr_r[r];
        rd = pend[r] && (!wr_r[r] || 1'($urandom_range(0, 1)));
        if (r == 0) begin
            rq0_if.read = rd; rq0_if.write = wr; rq0_if.addr = addr_r[r]; rq0_if.wdata = wdata_r[r];
        end else begin
            rq1_if.read = rd; rq1_if.write = wr; rq1_if.addr = addr_r[r]; rq1_if.wdata = wdata_r[r];
        end
    endtask

    task automatic new_req(input int r, input bit wr, input logic [AW-1:0] a, input logic [BW-1:0] d);
        pend[r] = 1'b1; wr_r[r] = wr; addr_r[r] = a; wdata_r[r] = d;
        drive_req(r);
    endtask

    task automatic rand_req(input int r);
        new_req(r, 1'($urandom_range(0, 1)), $urandom, rand_blk());
    endtask

    task automatic reset_model();
        for (int r = 0; r < 2; r++) begin
            pend[r] = 1'b0; drive_req(r);
            exp_rdata[r] = '0; exp_hit[r] = 1'b0; rdy_cnt[r] = 0;
        end
        exp_gid = 0; last_w = 1; exp_addr = '0; exp_wdata = '0; exp_wr = 1'b0;
        g = -1000; done_e = -1000; next_ok = 0; cmd_prev = 1'b0;
        obs_grant_edge.delete(); obs_grant_id.delete(); obs_ready_edge.delete();
        l2_if.ready = 1'b0; l2_if.hit = 1'b0; l2_if.rdata = '0;
    endtask

    task automatic check_all();
        bit cmd;
        cmd = (n >= g) && (n < done_e);
        check_val("grant_id", BW'(grant_id), BW'(exp_gid));
        check_val("l2_addr",  BW'(l2_if.addr), BW'(exp_addr));
        check_val("l2_wdata", BW'(l2_if.wdata), exp_wdata);
        check_val("l2_read",  BW'(l2_if.read), BW'(cmd && !exp_wr));
        check_val("l2_write", BW'(l2_if.write), BW'(cmd && exp_wr));
        check_val("ready0",   BW'(rq0_if.ready), BW'((n == done_e) && (cur_w == 0)));
        check_val("ready1",   BW'(rq1_if.ready), BW'((n == done_e) && (cur_w == 1)));
        check_val("rdata0",   BW'(rq0_if.rdata), exp_rdata[0]);
        check_val("rdata1",   BW'(rq1_if.rdata), exp_rdata[1]);
        check_val("hit0",     BW'(rq0_if.hit), BW'(exp_hit[0]));
        check_val("hit1",     BW'(rq1_if.hit), BW'(exp_hit[1]));
        check_val("busy",     BW'(busy), BW'((n >= g) && (n <= done_e)));
    endtask

    task automatic step();
        int w;
        bit cmd_now;
        n++;
        if ((n >= next_ok) && (pend[0] || pend[1])) begin
            if (pend[0] && pend[1]) w = 1 - last_w;
            else                    w = pend[1] ? 1 : 0;
            last_w = w; exp_gid = w; cur_w = w;
            exp_addr = addr_r[w]; exp_wdata = wdata_r[w]; exp_wr = wr_r[w];
            g = n;
            done_e  = n + ((k_force > 0) ? k_force : int'($urandom_range(1, 4)));
            next_ok = done_e + 2;
        end
        l2_if.rdata = rd_force ? rd_force_val : rand_blk();
        l2_if.hit   = rd_force ? hit_force_val : 1'($urandom_range(0, 1));
        if (n > g && n <= done_e) l2_if.ready = (n == done_e);
        else                      l2_if.ready = noise_one | 1'($urandom_range(0, 1));
        if (n == done_e) begin
            exp_rdata[cur_w] = l2_if.rdata;
            exp_hit[cur_w]   = l2_if.hit;
        end
        @(posedge clk); #1;
        cmd_now = l2_if.read | l2_if.write;
        if (cmd_now && !cmd_prev) begin
            obs_grant_edge.push_back(n);
            obs_grant_id.push_back(int'(grant_id));
        end
        cmd_prev = cmd_now;
        if (rq0_if.ready) begin rdy_cnt[0]++; obs_ready_edge.push_back(n); end
        if (rq1_if.ready) begin rdy_cnt[1]++; obs_ready_edge.push_back(n); end
        check_all();
        if (n == done_e) begin
            pend[cur_w] = 1'b0;
            drive_req(cur_w);
            if (hold_mode) rand_req(cur_w);
        end
        if (auto_req) begin
            for (int r = 0; r < 2; r++)
                if (!pend[r] && $urandom_range(0, 2) == 0) rand_req(r);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        reset_model();
        @(posedge clk); #1;
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        logic [BW-1:0] blk;

        // Reset values, then rq0 read with a 3-cycle L2 and l2_ready noise
        // held high in every IDLE/DONE cycle.
        do_reset();
        noise_one = 1'b1;
        repeat (3) step();
        rd_force = 1'b1;
        rd_force_val = rand_blk();
        rd_force_val[31:0] = 32'hDEAD_BEEF;
        hit_force_val = 1'b1;
        k_force = 3;
        new_req(0, 1'b0, 32'h0000_1000, '0);
        repeat (8) step();
        check_val("t1_l2_addr", BW'(l2_if.addr), BW'(32'h0000_1000));
        check_val("t1_ready0_cnt", BW'(rdy_cnt[0]), BW'(1));
        check_val("t1_ready1_cnt", BW'(rdy_cnt[1]), BW'(0));
        check_val("t1_word0", BW'(rq0_if.rdata[0]), BW'(32'hDEAD_BEEF));
        check_val("t1_hit0", BW'(rq0_if.hit), BW'(1'b1));
        check_val("t1_latency", BW'((obs_grant_edge.size() > 0 && obs_ready_edge.size() > 0)
                  ? obs_ready_edge[0] - obs_grant_edge[0] : 99), BW'(3));
        rd_force = 1'b0; noise_one = 1'b0; k_force = 0;

        // Both requesting from reset, held continuously: 0,1,0,1.
        do_reset();
        hold_mode = 1'b1;
        rand_req(0); rand_req(1);
        for (int i = 0; i < 40 && obs_grant_id.size() < 4; i++) step();
        hold_mode = 1'b0;
        for (int i = 0; i < 4; i++)
            check_val($sformatf("alt_%0d", i),
                      BW'((i < obs_grant_id.size()) ? obs_grant_id[i] : 9), BW'(i % 2));

        // rq1 write of a block with a known word 15.
        do_reset();
        blk = rand_blk();
        blk[15*DW +: DW] = 32'h1234_5678;
        new_req(1, 1'b1, 32'h0000_2000, blk);
        for (int i = 0; i < 4 && !(l2_if.read | l2_if.write); i++) step();
        check_val("t3_l2_write", BW'(l2_if.write), BW'(1'b1));
        check_val("t3_l2_read", BW'(l2_if.read), BW'(1'b0));
        check_val("t3_word15", BW'(l2_if.wdata[15]), BW'(32'h1234_5678));
        check_val("t3_addr", BW'(l2_if.addr), BW'(32'h0000_2000));
        for (int i = 0; i < 8 && rdy_cnt[1] == 0; i++) step();
        repeat (2) step();
        check_val("t3_ready1_cnt", BW'(rdy_cnt[1]), BW'(1));
        check_val("t3_ready0_cnt", BW'(rdy_cnt[0]), BW'(0));

        // l2_ready tied high, both held: grants 3 edges apart, ready 1 edge after grant.
        do_reset();
        k_force = 1; hold_mode = 1'b1;
        rand_req(0); rand_req(1);
        for (int i = 0; i < 30 && obs_grant_edge.size() < 4; i++) step();
        repeat (2) step();
        hold_mode = 1'b0; k_force = 0;
        for (int i = 1; i < 4; i++)
            check_val($sformatf("b2b_gap_%0d", i),
                      BW'((i < obs_grant_edge.size()) ? obs_grant_edge[i] - obs_grant_edge[i-1] : 99), BW'(3));
        for (int i = 0; i < 4; i++)
            check_val($sformatf("b2b_lat_%0d", i),
                      BW'((i < obs_grant_edge.size() && i < obs_ready_edge.size())
                          ? obs_ready_edge[i] - obs_grant_edge[i] : 99), BW'(1));

        // Reset asserted mid-ISSUE: command drops without a clock edge.
        do_reset();
        k_force = 8;
        new_req(0, 1'b0, 32'h0000_3000, rand_blk());
        for (int i = 0; i < 4 && !l2_if.read; i++) step();
        step();
        check_val("pre_rst_read", BW'(l2_if.read), BW'(1'b1));
        #2 rst = 1'b1;
        #1;
        check_val("rst_read_drop", BW'(l2_if.read), BW'(1'b0));
        check_val("rst_ready0", BW'(rq0_if.ready), BW'(1'b0));
        check_val("rst_busy", BW'(busy), BW'(1'b0));
        k_force = 0;
        do_reset();
        rand_req(0); rand_req(1);
        for (int i = 0; i < 4 && obs_grant_id.size() == 0; i++) step();
        check_val("post_rst_first", BW'((obs_grant_id.size() > 0) ? obs_grant_id[0] : 9), BW'(0));
        repeat (10) step();

        // Randomised traffic with random L2 latency and l2_ready noise.
        do_reset();
        auto_req = 1'b1;
        repeat (400) step();
        auto_req = 1'b0;
        check_val("rand_grants", BW'(obs_grant_edge.size() > 20), BW'(1'b1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
